// File: rtl/rgb565_gray_pack_ise_if.sv
`default_nettype none
// ============================================================================
//  Module   : rgb565_gray_pack_ise_if
//  Purpose  : Custom-instruction port bundle between the CPU (master) and the
//             grayscale pack unit (slave).
//  Signals  : start  - instruction-start strobe
//             iseId  - custom-instruction id presented with start
//             valueA - first operand (pixels 0/1 or packed weights)
//             valueB - second operand (pixels 2/3)
//             done   - one-cycle completion pulse
//             result - instruction result, zero whenever done is low
//  Revision : 1.0 - initial release
// ============================================================================
interface rgb565_gray_pack_ise_if;
  logic        start;
  logic [7:0]  iseId;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, iseId, valueA, valueB,
    input  done, result
  );

  modport slave (
    input  start, iseId, valueA, valueB,
    output done, result
  );
endinterface
`default_nettype wire

// File: rtl/rgb565_gray_pack_ise.sv
`default_nettype none
// ============================================================================
//  Module   : rgb565_gray_pack_ise
//  Purpose  : Multi-cycle custom instruction. Converts four RGB565 pixels into
//             four packed 8-bit gray values with programmable weights, or
//             swaps in a new weight set and returns the previous one.
//  Ports    : clock - system clock, rising edge
//             reset - synchronous active-high reset
//             bus   - custom-instruction port (slave side):
//                     start/iseId/valueA/valueB in, done/result out
//  Revision : 1.0 - initial release
// ============================================================================
module rgb565_gray_pack_ise #(
  parameter logic [7:0] customInstructionId = 8'h00,
  parameter int         weightWidth         = 8,
  parameter int         defaultWeightR      = 77,
  parameter int         defaultWeightG      = 150,
  parameter int         defaultWeightB      = 29
) (
  input  wire logic              clock,
  input  wire logic              reset,
  rgb565_gray_pack_ise_if.slave  bus
);

  localparam int             c_W          = weightWidth;
  localparam int             c_SUM_W      = c_W + 10;
  localparam logic [7:0]     c_CONVERT_ID = customInstructionId;
  // Set-weights id wraps within 8 bits.
  localparam logic [7:0]     c_WEIGHT_ID  = customInstructionId + 8'd1;
  localparam logic [c_W-1:0] c_DEF_R      = c_W'(defaultWeightR);
  localparam logic [c_W-1:0] c_DEF_G      = c_W'(defaultWeightG);
  localparam logic [c_W-1:0] c_DEF_B      = c_W'(defaultWeightB);
  localparam logic [c_SUM_W-1:0] c_ROUND  = c_SUM_W'(1) << (c_W - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_WEIGHT  = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t             r_state;
  logic [31:0]        r_op_a;
  logic [31:0]        r_op_b;
  logic [1:0]         r_k;
  logic [31:0]        r_acc;
  logic [c_W-1:0]     r_wr;
  logic [c_W-1:0]     r_wg;
  logic [c_W-1:0]     r_wb;
  logic               r_done;
  logic [31:0]        r_result;

  logic [15:0]        w_pixel;
  logic [7:0]         w_r8;
  logic [7:0]         w_g8;
  logic [7:0]         w_b8;
  logic [c_SUM_W-1:0] w_prod_r;
  logic [c_SUM_W-1:0] w_prod_g;
  logic [c_SUM_W-1:0] w_prod_b;
  logic [c_SUM_W-1:0] w_sum;
  logic [7:0]         w_gray;
  logic [31:0]        w_acc_next;

  // Pixel k of the latched operand pair.
  always_comb begin
    w_pixel = 16'h0000;
    case (r_k)
      2'd0: w_pixel = r_op_a[15:0];
      2'd1: w_pixel = r_op_a[31:16];
      2'd2: w_pixel = r_op_b[15:0];
      2'd3: w_pixel = r_op_b[31:16];
      default: w_pixel = 16'h0000;
    endcase
  end

  // Expand channels to 8 bits by replicating their MSBs into the LSBs.
  assign w_r8 = {w_pixel[15:11], w_pixel[15:13]};
  assign w_g8 = {w_pixel[10:5],  w_pixel[10:9]};
  assign w_b8 = {w_pixel[4:0],   w_pixel[4:2]};

  assign w_prod_r = {{10{1'b0}}, r_wr} * {{(c_SUM_W-8){1'b0}}, w_r8};
  assign w_prod_g = {{10{1'b0}}, r_wg} * {{(c_SUM_W-8){1'b0}}, w_g8};
  assign w_prod_b = {{10{1'b0}}, r_wb} * {{(c_SUM_W-8){1'b0}}, w_b8};
  assign w_sum    = w_prod_r + w_prod_g + w_prod_b + c_ROUND;

  // Any bit above the 8-bit gray field after the >>W shift means overflow.
  assign w_gray = (|w_sum[c_SUM_W-1:c_W+8]) ? 8'hFF : w_sum[c_W+7:c_W];

  always_comb begin
    w_acc_next = r_acc;
    case (r_k)
      2'd0: w_acc_next[7:0]   = w_gray;
      2'd1: w_acc_next[15:8]  = w_gray;
      2'd2: w_acc_next[23:16] = w_gray;
      2'd3: w_acc_next[31:24] = w_gray;
      default: w_acc_next = r_acc;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op_a   <= 32'd0;
      r_op_b   <= 32'd0;
      r_k      <= 2'd0;
      r_acc    <= 32'd0;
      r_wr     <= c_DEF_R;
      r_wg     <= c_DEF_G;
      r_wb     <= c_DEF_B;
      r_done   <= 1'b0;
      r_result <= 32'd0;
    end else begin
      // Outputs are only non-zero for the single cycle spent in S_DONE.
      r_done   <= 1'b0;
      r_result <= 32'd0;
      case (r_state)
        S_IDLE: begin
          if (bus.start && (bus.iseId == c_CONVERT_ID)) begin
            r_op_a  <= bus.valueA;
            r_op_b  <= bus.valueB;
            r_k     <= 2'd0;
            r_acc   <= 32'd0;
            r_state <= S_CONVERT;
          end else if (bus.start && (bus.iseId == c_WEIGHT_ID)) begin
            r_acc   <= {{(32-3*c_W){1'b0}}, r_wr, r_wg, r_wb};
            r_wr    <= bus.valueA[3*c_W-1:2*c_W];
            r_wg    <= bus.valueA[2*c_W-1:c_W];
            r_wb    <= bus.valueA[c_W-1:0];
            r_state <= S_WEIGHT;
          end
        end
        S_CONVERT: begin
          r_acc <= w_acc_next;
          r_k   <= r_k + 2'd1;
          if (r_k == 2'd3) begin
            r_done   <= 1'b1;
            r_result <= w_acc_next;
            r_state  <= S_DONE;
          end
        end
        S_WEIGHT: begin
          r_done   <= 1'b1;
          r_result <= r_acc;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_acc   <= 32'd0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule
`default_nettype wire

// File: doc/rgb565_gray_pack_ise.md
# rgb565_gray_pack_ise

Multi-cycle custom-instruction unit that converts four RGB565 pixels per instruction into four packed 8-bit grayscale values using run-time programmable luminance weights. It is the parametrised successor of the single-pixel, fixed-weight grayscale instruction. It attaches to the CPU custom-instruction port, shares the port's OR-combined result bus, and is used by the camera/display path to halve memory traffic per converted pixel.

## Interface
Parameters:
- customInstructionId, 8'h00, id of the convert operation; id customInstructionId+1 (8-bit wrap) is the set-weights operation.
- weightWidth, 8, fractional bits W of each weight; legal range 4..10 (3W ≤ 32).
- defaultWeightR, 77, reset value of the red weight (W bits).
- defaultWeightG, 150, reset value of the green weight.
- defaultWeightB, 29, reset value of the blue weight.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  instruction-start strobe from the CPU; qualified by iseId.
- iseId  in  8  custom-instruction id presented with start.
- valueA  in  32  convert: pixel0 = [15:0], pixel1 = [31:16]; set-weights: wr = [3W-1:2W], wg = [2W-1:W], wb = [W-1:0].
- valueB  in  32  convert: pixel2 = [15:0], pixel3 = [31:16]; ignored for set-weights.
- done  out  1  one-cycle completion pulse.
- result  out  32  convert: gray k in byte k; set-weights: previous weights packed as in valueA, upper bits 0. Must be 32'd0 whenever done = 0.

## Operation
- Reset: state IDLE, done = 0, result = 0, weights = defaults, operand registers cleared.
- FSM states: IDLE, CONVERT, WEIGHT, DONE.
- IDLE: start=1 and iseId==customInstructionId → latch valueA/valueB, pixel index k=0, go CONVERT. start=1 and iseId==customInstructionId+1 → capture old weights into result register, load new weights from valueA, go WEIGHT. Any other iseId or start=0 → stay IDLE, no state change.
- CONVERT: one pixel per cycle, k = 0..3; writes gray(pixel k) into byte k of the result register; after k=3 go DONE.
- WEIGHT: go DONE next cycle.
- DONE: done = 1, result = result register for exactly this cycle; next state IDLE; result register cleared.
- start while not IDLE is ignored (no queuing, no restart).
- Per-pixel arithmetic: expand R8 = {r5, r5[4:2]}, G8 = {g6, g6[5:4]}, B8 = {b5, b5[4:2]}; sum = wr·R8 + wg·G8 + wb·B8 + 2^(W-1), width W+10 bits; gray = sum >> W, saturated to 255 if larger.
- Weights are unsigned; weight sum is not constrained — saturation covers overflow.
- reset asserted in any state: next cycle is IDLE with outputs and weights at reset values; a conversion in flight is abandoned and never signals done.

## Timing
- Convert: start sampled at edge t0; CONVERT during cycles t0+1..t0+4; done = 1 in cycle t0+5 only. Latency 5 cycles, issue interval 6 cycles.
- Set-weights: start at edge t0; WEIGHT at t0+1; done = 1 in cycle t0+2. New weights apply to any convert started at or after t0+2.
- done and result are registered outputs; no combinational path from inputs to outputs.
- result is exactly 0 in every cycle where done = 0, including during reset.

## Test plan
- Reset: hold reset 2 cycles with start=1 and matching id → done = 0, result = 0 throughout; first convert after release behaves normally.
- Default convert: iseId=0x00, valueA=0xF800FFFF, valueB=0x001F07E0 → done pulses in cycle t0+5 only, result = 0x1D954DFF; black pixels (all zeros) → 0x00000000.
- Set weights: iseId=0x01, valueA=0x00FF0000 → done at t0+2, result = 0x004D961D. A following convert with valueA=0xF800FFFF, valueB=0x07E0001F → result = 0x0000FEFE.
- Saturation: set weights valueA=0x00FFFFFF, then convert white 0xFFFF in all four slots → result = 0xFFFFFFFF (unclamped value 762 per pixel).
- Id filtering and busy: start with iseId=0x05 → no done, result 0. Second matching start at t0+2 during CONVERT → ignored; exactly one done pulse at t0+5.
- Reset mid-operation: start convert, assert reset for 1 cycle at t0+2 → no done pulse; weights return to defaults; the next convert of 0xF800 in pixel0 yields byte0 = 0x4D.
